rr_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the common memory bus (address/read/write/mask/value, ready/fault) between N bus masters, e.g. CPU instruction port, CPU data port and a future DMA engine. It sits between the masters and the address-decoded peripheral fabric (RAM, GPIO, UART, timer, flash). It grants one master per transaction and holds the grant until the slave answers. A watchdog terminates stalled transactions with a fault, so a missing `ready` never hangs the core.

---
 rtl/rr_mem_arbiter.sv | 107 ++++++++++
 tb/tb_rr_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mem_arbiter.sv
// rr_mem_arbiter: round-robin arbiter sharing one memory bus among N masters, with a watchdog timeout
// Ports:
//   clk, reset_n        : clock and asynchronous active-low reset
//   m_*_in / m_*_out    : per-master request fields and responses, master i in slice i
//   *_out / *_in (bus)  : common bus request fields and the slave's response
//   grant_out, busy_out : one-hot current grant and BUSY-state indicator
module rr_mem_arbiter #(
    parameter int N       = 3,
    parameter int TIMEOUT = 256
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N*32-1:0] m_address_in,
    input  logic [N-1:0]    m_read_in,
    input  logic [N-1:0]    m_write_in,
    input  logic [N*4-1:0]  m_write_mask_in,
    input  logic [N*32-1:0] m_write_value_in,
    output logic [N*32-1:0] m_read_value_out,
    output logic [N-1:0]    m_ready_out,
    output logic [N-1:0]    m_fault_out,
    output logic [31:0]     address_out,
    output logic            read_out,
    output logic            write_out,
    output logic [3:0]      write_mask_out,
    output logic [31:0]     write_value_out,
    input  logic [31:0]     read_value_in,
    input  logic            ready_in,
    input  logic            fault_in,
    output logic [N-1:0]    grant_out,
    output logic            busy_out
);
    localparam int PW = N > 1 ? $clog2(N) : 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    logic [0:0]    state;
    logic [N-1:0]  grant, nxt, req;
    logic [PW-1:0] ptr, nptr;
    logic [CW-1:0] cnt;
    logic          g_req, tmo, done;
    int            best, sel;
    assign req   = m_read_in | m_write_in;
    assign g_req = |(grant & req);
    assign tmo   = cnt == CW'(TIMEOUT - 1);
    // A dropped request (abort), a slave ready or the watchdog all end the transaction.
    assign done  = ~g_req | ready_in | tmo;
    // Pick the requester with the smallest distance upward from ptr, wrapping modulo N.
    always_comb begin
        best = N;
        sel  = 0;
        nxt  = '0;
        nptr = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && ((i - int'(ptr) + N) % N) < best) begin
                best = (i - int'(ptr) + N) % N;
                sel  = i;
            end
        end
        for (int i = 0; i < N; i++) begin
            nxt[i] = req[i] && (i == sel);
            if (grant[i]) nptr = PW'((i + 1) % N);
        end
    end
    // Grant is one-hot and zero in IDLE, so all bus and response outputs fall to zero there.
    always_comb begin
        address_out      = '0;
        write_value_out  = '0;
        write_mask_out   = '0;
        m_read_value_out = '0;
        m_ready_out      = '0;
        m_fault_out      = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                address_out                = m_address_in[32*i +: 32];
                write_value_out            = m_write_value_in[32*i +: 32];
                write_mask_out             = m_write_in[i] ? m_write_mask_in[4*i +: 4] : 4'b0;
                m_ready_out[i]             = g_req & (ready_in | tmo);
                m_fault_out[i]             = g_req & (ready_in ? fault_in : tmo);
                m_read_value_out[32*i +: 32] = (g_req & ready_in) ? read_value_in : 32'h0;
            end
        end
    end
    assign read_out  = |(grant & m_read_in);
    assign write_out = |(grant & m_write_in);
    assign grant_out = grant;
    assign busy_out  = state == BUSY;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else if (state == IDLE) begin
            if (|req) begin
                state <= BUSY;
                grant <= nxt;
                cnt   <= '0;
            end
        end else if (done) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= nptr;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_rr_mem_arbiter.sv
// tb_rr_mem_arbiter: directed and randomized checks of rr_mem_arbiter against a transaction-level model
module tb_rr_mem_arbiter;
    localparam int N  = 3;
    localparam int TO = 4;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;
    logic [31:0]     addr[N];
    logic [31:0]     wdat[N];
    logic [3:0]      mask[N];
    logic [N-1:0]    rd, wr;
    logic [N*32-1:0] m_address_in, m_write_value_in, m_read_value_out;
    logic [N*4-1:0]  m_write_mask_in;
    logic [N-1:0]    m_ready_out, m_fault_out, grant_out;
    logic [31:0]     address_out, write_value_out, read_value_in;
    logic [3:0]      write_mask_out;
    logic            read_out, write_out, ready_in, fault_in, busy_out;
    always_comb begin
        for (int i = 0; i < N; i++) begin
            m_address_in[32*i +: 32]     = addr[i];
            m_write_value_in[32*i +: 32] = wdat[i];
            m_write_mask_in[4*i +: 4]    = mask[i];
        end
    end
    rr_mem_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .m_address_in(m_address_in), .m_read_in(rd), .m_write_in(wr),
        .m_write_mask_in(m_write_mask_in), .m_write_value_in(m_write_value_in),
        .m_read_value_out(m_read_value_out), .m_ready_out(m_ready_out), .m_fault_out(m_fault_out),
        .address_out(address_out), .read_out(read_out), .write_out(write_out),
        .write_mask_out(write_mask_out), .write_value_out(write_value_out),
        .read_value_in(read_value_in), .ready_in(ready_in), .fault_in(fault_in),
        .grant_out(grant_out), .busy_out(busy_out)
    );
    int checks = 0;
    int failures = 0;
    bit mbusy;
    logic [1:0] mg;
    int mptr, mcnt;
    logic [N-1:0] exp_ready, last_ready;
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        mbusy = 0;
        mptr  = 0;
        mcnt  = 0;
        mg    = 0;
    endtask
    // Expected outputs follow from the current transaction: who owns the bus, how long it has waited, and the slave's answer.
    task automatic check();
        logic reqg, rdy, tmo;
        logic [N-1:0] ef;
        logic [N*32-1:0] erv;
        #1;
        reqg = mbusy && (rd[mg] | wr[mg]);
        rdy  = reqg && ready_in;
        tmo  = reqg && !ready_in && mcnt == TO - 1;
        exp_ready = (rdy || tmo) ? N'(1 << mg) : '0;
        ef = (rdy ? fault_in : tmo) ? N'(1 << mg) : '0;
        erv = '0;
        if (rdy) erv[32*mg +: 32] = read_value_in;
        chk("grant", grant_out, mbusy ? N'(1 << mg) : '0);
        chk("busy", busy_out, mbusy);
        chk("m_ready", m_ready_out, exp_ready);
        chk("m_fault", m_fault_out, ef);
        chk("m_read_value", m_read_value_out, erv);
        chk("address", address_out, mbusy ? addr[mg] : 32'h0);
        chk("read", read_out, mbusy && rd[mg]);
        chk("write", write_out, mbusy && wr[mg]);
        chk("mask", write_mask_out, (mbusy && wr[mg]) ? mask[mg] : 4'h0);
        chk("wvalue", write_value_out, mbusy ? wdat[mg] : 32'h0);
    endtask
    task automatic tick();
        bit found;
        @(posedge clk);
        if (!mbusy) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && (rd[(mptr + k) % N] | wr[(mptr + k) % N])) begin
                    mg = 2'((mptr + k) % N);
                    found = 1;
                end
            end
            if (found) begin
                mbusy = 1;
                mcnt  = 0;
            end
        end else if (!(rd[mg] | wr[mg]) || ready_in || mcnt == TO - 1) begin
            mbusy = 0;
            mptr  = (mg + 1) % N;
        end else begin
            mcnt++;
        end
        @(negedge clk);
    endtask
    initial begin
        rd = '0; wr = '0; ready_in = 0; fault_in = 0; read_value_in = '0; last_ready = '0;
        for (int i = 0; i < N; i++) begin
            addr[i] = '0; wdat[i] = '0; mask[i] = '0;
        end
        model_reset();
        #1 reset_n = 0;
        check();
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        // single zero-wait read from master 1
        addr[1] = 32'h00010004; rd[1] = 1;
        check(); tick();
        ready_in = 1; read_value_in = 32'h5;
        check();
        chk("sr_addr", address_out, 32'h00010004);
        chk("sr_ready", m_ready_out, 3'b010);
        chk("sr_rvalue", m_read_value_out[63:32], 32'h5);
        tick();
        rd[1] = 0; ready_in = 0;
        check();
        chk("sr_idle_grant", grant_out, 3'b000);
        tick();
        // fairness from a fresh reset with all masters requesting
        reset_n = 0; model_reset();
        @(negedge clk);
        reset_n = 1;
        for (int i = 0; i < N; i++) addr[i] = $urandom;
        rd = 3'b111; ready_in = 1; read_value_in = $urandom;
        for (int k = 0; k < 12; k++) begin
            check();
            chk("rr_grant", grant_out, (k % 2) ? 3'(1 << ((k / 2) % 3)) : 3'b000);
            tick();
        end
        rd = '0; ready_in = 0;
        check(); tick();
        // write masking, then a read that must not leak its mask
        wr[2] = 1; mask[2] = 4'b0011; wdat[2] = 32'hDEADBEEF; addr[2] = 32'h00020000;
        check(); tick();
        ready_in = 1;
        check();
        chk("wm_write", write_out, 1'b1);
        chk("wm_mask", write_mask_out, 4'b0011);
        chk("wm_value", write_value_out, 32'hDEADBEEF);
        tick();
        wr[2] = 0; ready_in = 0;
        check(); tick();
        rd[2] = 1; mask[2] = 4'hF;
        check(); tick();
        ready_in = 1;
        check();
        chk("rd_mask", write_mask_out, 4'h0);
        chk("rd_read", read_out, 1'b1);
        tick();
        rd[2] = 0; ready_in = 0;
        check(); tick();
        // watchdog timeout on master 0 while master 1 waits
        addr[0] = 32'h00030000; rd[0] = 1; rd[1] = 1;
        check(); tick();
        for (int k = 1; k <= TO; k++) begin
            check();
            chk("to_ready", m_ready_out[0], k == TO);
            chk("to_fault", m_fault_out[0], k == TO);
            tick();
        end
        rd[0] = 0;
        check();
        chk("to_bubble", grant_out, 3'b000);
        tick();
        ready_in = 1;
        check();
        chk("to_next", grant_out, 3'b010);
        tick();
        rd[1] = 0; ready_in = 0;
        check(); tick();
        // slave fault passthrough after one wait state
        addr[1] = 32'h00050000; rd[1] = 1;
        check(); tick();
        check(); tick();
        ready_in = 1; fault_in = 1; read_value_in = 32'h0;
        check();
        chk("sf_fault", m_fault_out[1], 1'b1);
        chk("sf_rvalue", m_read_value_out[63:32], 32'h0);
        tick();
        rd[1] = 0; ready_in = 0; fault_in = 0;
        check(); tick();
        // abort: granted master drops its request
        rd[2] = 1;
        check(); tick();
        check(); tick();
        rd[2] = 0; ready_in = 1;
        check();
        chk("abort_noready", m_ready_out, 3'b000);
        tick();
        ready_in = 0;
        check();
        chk("abort_idle", grant_out, 3'b000);
        tick();
        // asynchronous reset during a wait-stated transaction
        rd[2] = 1;
        check(); tick();
        check();
        #2 reset_n = 0;
        model_reset();
        check();
        chk("rst_busy", busy_out, 1'b0);
        chk("rst_grant", grant_out, 3'b000);
        chk("rst_strobes", {read_out, write_out}, 2'b00);
        chk("rst_noready", m_ready_out, 3'b000);
        @(negedge clk);
        reset_n = 1;
        rd[0] = 1;
        check(); tick();
        ready_in = 1;
        check();
        chk("rst_prio", grant_out, 3'b001);
        tick();
        rd[0] = 0; ready_in = 0;
        // randomized traffic; masters hold fields until they see ready
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (last_ready[i]) begin
                    rd[i] = 0; wr[i] = 0;
                end else if (!(rd[i] | wr[i]) && $urandom_range(0, 2) == 0) begin
                    addr[i] = $urandom; wdat[i] = $urandom; mask[i] = 4'($urandom);
                    wr[i] = 1'($urandom_range(0, 1)); rd[i] = ~wr[i];
                end
            end
            ready_in = $urandom_range(0, 9) < 4;
            fault_in = $urandom_range(0, 4) == 0;
            read_value_in = $urandom;
            check();
            last_ready = exp_ready;
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
